// File: rtl/freq_meas_sched.sv
// freq_meas_sched: sweeps the masked input channels and measures rising edges and high time
// over a programmable window with one shared counter pair. Macro FREQ_SCHED_CONT_EN: continuous sweep.
module freq_meas_sched #(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [CH_NUM-1:0] in_sig,
    input  logic              start,
    input  logic              abort,
    input  logic [CH_NUM-1:0] chan_mask,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [2:0]        res_chan,
    output logic [CNT_W-1:0]  res_edges,
    output logic [CNT_W-1:0]  res_high,
    output logic              res_sat,
    output logic              busy
);
    localparam int unsigned CH_W       = 3;
    localparam int unsigned SETTLE_CYC = 3;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   w_chan_nxt;
    logic [CH_NUM-1:0] r_sync1;
    logic [CH_NUM-1:0] r_sync2;
    logic [CH_NUM-1:0] r_mask;
    logic [CNT_W-1:0]  r_win;
    logic [CNT_W-1:0]  r_tmr;
    logic [CNT_W-1:0]  r_edges;
    logic [CNT_W-1:0]  r_high;
    logic              r_prev;
    logic [CH_W-1:0]   r_chan;
    logic [7:0]        w_sync_pad;
    logic              w_sel;
    logic [CNT_W-1:0]  w_win_last;
    logic [CNT_W-1:0]  w_edges_inc;
    logic [CNT_W-1:0]  w_high_inc;
    logic [CH_W-1:0]   w_first_idx;
    logic [CH_W-1:0]   w_next_idx;
    logic              w_next_found;
`ifdef FREQ_SCHED_CONT_EN
    logic [CH_W-1:0]   w_wrap_idx;
`endif

    assign w_sync_pad  = 8'(r_sync2);
    assign w_sel       = w_sync_pad[r_chan];
    assign w_win_last  = (r_win == '0) ? '0 : r_win - CNT_W'(1);
    assign w_edges_inc = (w_sel && !r_prev && (r_edges != CNT_MAX)) ? r_edges + CNT_W'(1) : r_edges;
    assign w_high_inc  = (w_sel && (r_high != CNT_MAX)) ? r_high + CNT_W'(1) : r_high;

    // Lowest set bit of the incoming mask, and lowest latched channel above the current one
    always_comb begin
        w_first_idx  = '0;
        w_next_idx   = '0;
        w_next_found = 1'b0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (chan_mask[i]) w_first_idx = CH_W'(i);
            if (r_mask[i] && (CH_W'(i) > r_chan)) begin
                w_next_found = 1'b1;
                w_next_idx   = CH_W'(i);
            end
        end
    end

`ifdef FREQ_SCHED_CONT_EN
    always_comb begin
        w_wrap_idx = '0;
        for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
            if (r_mask[i]) w_wrap_idx = CH_W'(i);
        end
    end
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and channel selection; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        case (r_state)
            IDLE: begin
                if (start && (chan_mask != '0)) begin
                    w_state_nxt = SETTLE;
                    w_chan_nxt  = w_first_idx;
                end
            end
            SETTLE:  if (r_tmr == SETTLE_LAST) w_state_nxt = MEASURE;
            MEASURE: if (r_tmr == w_win_last)  w_state_nxt = REPORT;
            REPORT: begin
                if (res_valid && res_ready) begin
                    if (w_next_found) begin
                        w_state_nxt = SETTLE;
                        w_chan_nxt  = w_next_idx;
                    end else begin
`ifdef FREQ_SCHED_CONT_EN
                        w_state_nxt = SETTLE;
                        w_chan_nxt  = w_wrap_idx;
`else
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_mask    <= '0;
            r_win     <= '0;
            r_tmr     <= '0;
            r_edges   <= '0;
            r_high    <= '0;
            r_prev    <= 1'b0;
            r_chan    <= '0;
            res_valid <= 1'b0;
            res_chan  <= '0;
            res_edges <= '0;
            res_high  <= '0;
            res_sat   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_sync1 <= in_sig;
            r_sync2 <= r_sync1;
            r_chan  <= w_chan_nxt;
            if (r_state == IDLE && w_state_nxt == SETTLE) begin
                r_mask <= chan_mask;
                r_win  <= win_len;
            end
            if (w_state_nxt != r_state || r_state == IDLE || r_state == REPORT) r_tmr <= '0;
            else                                                                 r_tmr <= r_tmr + CNT_W'(1);
            // History reloads in SETTLE so a channel switch never looks like an edge
            case (r_state)
                SETTLE: begin
                    r_edges <= '0;
                    r_high  <= '0;
                    r_prev  <= w_sel;
                end
                MEASURE: begin
                    r_edges <= w_edges_inc;
                    r_high  <= w_high_inc;
                    r_prev  <= w_sel;
                end
                default: ;
            endcase
            if (abort) begin
                r_edges <= '0;
                r_high  <= '0;
            end
            res_valid <= (w_state_nxt == REPORT);
            busy      <= (w_state_nxt != IDLE);
            if (r_state == MEASURE && w_state_nxt == REPORT) begin
                res_chan  <= r_chan;
                res_edges <= w_edges_inc;
                res_high  <= w_high_inc;
                res_sat   <= (&w_edges_inc) | (&w_high_inc);
            end
        end
    end
endmodule

// File: doc/freq_meas_sched.md
FREQ_MEAS_SCHED -- requirements
Module: freq_meas_sched

Interface
REQ-001 Parameter CH_NUM, default 4: number of measured input channels (2..8).
REQ-002 Parameter CNT_W, default 16: width of the window length, edge count and high count.
REQ-003 clock  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_sig  input  CH_NUM  asynchronous signals to be measured.
REQ-006 start  input  1  one-cycle pulse that starts a sweep.
REQ-007 abort  input  1  one-cycle pulse that cancels the current sweep.
REQ-008 chan_mask  input  CH_NUM  channels included in the sweep; sampled on an accepted start.
REQ-009 win_len  input  CNT_W  measurement window length in clock cycles; sampled on an accepted start.
REQ-010 res_ready  input  1  downstream accepts the result.
REQ-011 res_valid  output  1  result is available.
REQ-012 res_chan  output  3  index of the measured channel.
REQ-013 res_edges  output  CNT_W  number of rising edges in the window.
REQ-014 res_high  output  CNT_W  number of clock cycles the signal was high in the window.
REQ-015 res_sat  output  1  a counter saturated during the window.
REQ-016 busy  output  1  asserted whenever the FSM is not in IDLE.

Function
REQ-017 Each in_sig bit SHALL pass through a 2-flop synchronizer before use; a single shared edge/high counter pair SHALL be multiplexed onto the selected channel.
REQ-018 FSM states SHALL be IDLE, SETTLE, MEASURE and REPORT.
REQ-019 Transitions:
- IDLE -> SETTLE: on start with a nonzero chan_mask; the lowest set mask bit is selected.
- IDLE: start with chan_mask equal to 0 is ignored.
- SETTLE -> MEASURE: after exactly 3 cycles.
- MEASURE -> REPORT: after exactly max(win_len,1) cycles.
- REPORT -> SETTLE: on the res_valid and res_ready handshake, if a higher masked channel remains; that channel is selected.
- REPORT -> IDLE: on the handshake, if no higher masked channel remains.
REQ-020 In SETTLE the counters SHALL clear and the edge-detect history SHALL load the selected synchronized value, so that no edge spanning a channel switch is counted.
REQ-021 In MEASURE, on each cycle:
- the edge counter increments when the synchronized signal is 1 and its previous value was 0;
- the high counter increments when the synchronized signal is 1.
REQ-022 Both counters SHALL saturate at all-ones; any saturation sets res_sat for that result.
REQ-023 res_valid SHALL assert on the first REPORT cycle, and res_* SHALL stay stable until the handshake.
REQ-024 res_valid SHALL deassert on the cycle after the handshake.
REQ-025 start while busy SHALL be ignored.
REQ-026 abort in any state SHALL force IDLE on the next cycle, deassert res_valid and discard the counters; abort SHALL take priority over start and over the handshake in the same cycle.
REQ-027 Latency: for an accepted start at cycle 0 with win_len=N, res_valid SHALL be 1 at cycle 4+N.

Reset
REQ-028 rst_n low SHALL, asynchronously:
- put the FSM in IDLE;
- set res_valid, res_sat and busy to 0;
- set res_chan, res_edges and res_high to 0;
- clear all synchronizer, counter and latched configuration registers.
REQ-029 Reset release mid-sweep SHALL resume in IDLE only; no partial result is emitted.

Configuration
REQ-030 With macro FREQ_SCHED_CONT_EN defined, REPORT SHALL wrap from the last masked channel back to SETTLE on the lowest masked channel, using the latched mask and win_len, until abort; busy stays 1.
REQ-031 Without FREQ_SCHED_CONT_EN, the sweep SHALL end in IDLE after the last masked channel (REQ-019).

Verification
REQ-032 Mask 4'b0001, win_len=1000, in_sig[0] with period 10 cycles and 50% duty -> res_chan=0, res_edges=100 (+/-1), res_high=500 (+/-5), res_sat=0.
REQ-033 Mask 4'b1010, res_ready held 1 -> two results, res_chan=1 then res_chan=3, then busy=0; with res_ready held 0 for 20 cycles, res_* is stable throughout.
REQ-034 win_len=16'hFFFF, in_sig[0] held high -> res_high=16'hFFFF and res_sat=1; win_len=0 -> one-cycle window and res_valid at cycle 5.
REQ-035 abort asserted mid-MEASURE, together with start -> IDLE on the next cycle, no res_valid, start ignored; start with mask=0 -> busy remains 0.
REQ-036 rst_n pulsed low while in REPORT -> all outputs 0 immediately; with FREQ_SCHED_CONT_EN, mask 4'b0011 -> result sequence 0,1,0,1... until abort.
